// File: rtl/ltc2333_pkg.sv
// Shared types and constants for the LTC2333 conversion/readout engine.
package ltc2333_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNV_HI,
    WAIT_BUSY,
    SHIFT,
    DRAIN,
    GAP
  } state_t;

  localparam int WORD_W    = 24;
  localparam int RES_MSB   = 23;
  localparam int RES_LSB   = 6;
  localparam int CH_MSB    = 5;
  localparam int CH_LSB    = 3;
  localparam int SS_MSB    = 2;
  localparam int SS_LSB    = 0;
  localparam int MAX_WORDS = 8;

  // A request of zero words still reads one; anything past the frame buffer depth clamps.
  function automatic logic [3:0] clamp_words(input logic [3:0] n);
    logic [3:0] r;
    r = n;
    if (n == 4'd0) r = 4'd1;
    else if (n > 4'(MAX_WORDS)) r = 4'(MAX_WORDS);
    return r;
  endfunction

endpackage

// File: rtl/ltc2333_lane_capture.sv
// One ADC lane: synchronises the echo clock and data, shifts bits MSB first
// and publishes each completed 24-bit word with a running word count.
module ltc2333_lane_capture
  import ltc2333_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              flush,
  input  logic [3:0]        n_words,
  input  logic [3:0]        push_idx,
  input  logic              scko,
  input  logic              sdo,
  output logic [WORD_W-1:0] word,
  output logic [3:0]        word_cnt
);

  logic [2:0]        scko_sync;
  logic [1:0]        sdo_sync;
  logic [WORD_W-1:0] shreg;
  logic [4:0]        bit_cnt;
  logic              scko_rise;
  logic [WORD_W-1:0] shifted;

  assign scko_rise = scko_sync[1] & ~scko_sync[2];
  assign shifted   = {shreg[WORD_W-2:0], sdo_sync[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scko_sync <= '0;
      sdo_sync  <= '0;
    end else begin
      scko_sync <= {scko_sync[1:0], scko};
      sdo_sync  <= {sdo_sync[0], sdo};
    end
  end

  // A flush closes the word the output stage is waiting on, padding missing bits with zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      word     <= '0;
    end else if (flush && (word_cnt == push_idx)) begin
      word     <= shreg << (5'(WORD_W) - bit_cnt);
      word_cnt <= word_cnt + 4'd1;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (scko_rise && (word_cnt < n_words)) begin
      if (bit_cnt == 5'(WORD_W - 1)) begin
        word     <= shifted;
        word_cnt <= word_cnt + 4'd1;
        bit_cnt  <= '0;
        shreg    <= '0;
      end else begin
        shreg   <= shifted;
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/ltc2333_readout.sv
// Conversion and serial readout engine for a bank of LTC2333 ADCs sharing
// CNV/SCKI/SDI, streaming one N_ADC-wide word per readout slot.
module ltc2333_readout
  import ltc2333_pkg::*;
#(
  parameter int N_ADC    = 8,
  parameter int CLK_DIV  = 4,
  parameter int CNV_CYC  = 4,
  parameter int BUSY_TO  = 2000,
  parameter int DRAIN_TO = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [31:0]             period,
  input  logic [3:0]              n_words,
  input  logic [WORD_W-1:0]       cfg_word,
  output logic                    cnv,
  output logic                    scki,
  output logic                    sdi,
  input  logic [N_ADC-1:0]        busy,
  input  logic [N_ADC-1:0]        scko,
  input  logic [N_ADC-1:0]        sdo,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WORD_W*N_ADC-1:0] m_data,
  output logic                    m_last,
  output logic                    busy_timeout,
  output logic [15:0]             overrun_cnt
);

  state_t state, state_nxt;

  logic [15:0]             tmr;
  logic [31:0]             per_cnt;
  logic                    trigger;
  logic [N_ADC-1:0]        busy_s1, busy_s2;
  logic                    busy_clear;
  logic [WORD_W-1:0]       cfg_q, sdi_sr;
  logic [3:0]              n_eff, push_idx;
  logic [15:0]             div_cnt;
  logic [9:0]              half_cnt, half_total;
  logic                    shift_last;
  logic                    frame_start, shift_start, timeout_hit, flush;
  logic [WORD_W-1:0]       lane_word [N_ADC];
  logic [3:0]              lane_cnt  [N_ADC];
  logic [WORD_W*N_ADC-1:0] lane_bus;
  logic                    all_ready, push;

  assign trigger    = enable && (({1'b0, per_cnt} + 33'd1) >= {1'b0, period});
  assign busy_clear = ~|busy_s2;
  assign half_total = 10'(n_eff) * 10'd48;
  assign shift_last = (state == SHIFT) && (div_cnt == 16'(CLK_DIV - 1))
                      && (half_cnt == half_total - 10'd1);
  assign sdi        = sdi_sr[WORD_W-1];
  assign push       = all_ready && (push_idx < n_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (trigger) state_nxt = CNV_HI;
      CNV_HI:    if (tmr == 16'(CNV_CYC - 1)) state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy_clear) state_nxt = SHIFT;
        else if (tmr == 16'(BUSY_TO - 1)) state_nxt = GAP;
      end
      SHIFT:     if (shift_last) state_nxt = DRAIN;
      DRAIN:     if (push_idx == n_eff) state_nxt = GAP;
      GAP:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnv         = (state == CNV_HI);
    frame_start = (state == IDLE) && trigger;
    shift_start = (state == WAIT_BUSY) && busy_clear;
    timeout_hit = (state == WAIT_BUSY) && !busy_clear && (tmr == 16'(BUSY_TO - 1));
    flush       = (state == DRAIN) && (tmr >= 16'(DRAIN_TO - 1));
  end

  // The period counter spans the whole frame so CNV edges stay exactly period apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr     <= '0;
      per_cnt <= '0;
      busy_s1 <= '0;
      busy_s2 <= '0;
    end else begin
      tmr     <= (state_nxt != state) ? 16'd0 : tmr + 16'd1;
      busy_s1 <= busy;
      busy_s2 <= busy_s1;
      if (frame_start)                   per_cnt <= '0;
      else if (state == IDLE && !enable) per_cnt <= '0;
      else if (per_cnt != '1)            per_cnt <= per_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q        <= '0;
      n_eff        <= 4'd1;
      busy_timeout <= 1'b0;
    end else if (frame_start) begin
      cfg_q        <= cfg_word;
      n_eff        <= clamp_words(n_words);
      busy_timeout <= 1'b0;
    end else if (timeout_hit) begin
      busy_timeout <= 1'b1;
    end
  end

  // SCKI idles low; SDI advances on each falling edge and zero-fills after the config word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scki     <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      sdi_sr   <= '0;
    end else if (shift_start) begin
      scki     <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      sdi_sr   <= cfg_q;
    end else if (state == SHIFT) begin
      if (div_cnt == 16'(CLK_DIV - 1)) begin
        div_cnt  <= '0;
        half_cnt <= half_cnt + 10'd1;
        scki     <= ~scki;
        if (scki) sdi_sr <= sdi_sr << 1;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end else begin
      scki <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_ADC; g++) begin : g_lane
    ltc2333_lane_capture u_lane (
      .clk      (clk),
      .rst      (rst),
      .clear    (frame_start),
      .flush    (flush),
      .n_words  (n_eff),
      .push_idx (push_idx),
      .scko     (scko[g]),
      .sdo      (sdo[g]),
      .word     (lane_word[g]),
      .word_cnt (lane_cnt[g])
    );
  end

  always_comb begin
    all_ready = 1'b1;
    lane_bus  = '0;
    for (int i = 0; i < N_ADC; i++) begin
      if (lane_cnt[i] <= push_idx) all_ready = 1'b0;
      lane_bus[WORD_W*i +: WORD_W] = lane_word[i];
    end
  end

  // A word arriving while the previous one is still held is dropped and counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_idx    <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      overrun_cnt <= '0;
    end else if (frame_start) begin
      push_idx <= '0;
      if (m_valid && m_ready) m_valid <= 1'b0;
    end else if (push) begin
      push_idx <= push_idx + 4'd1;
      if (!m_valid || m_ready) begin
        m_valid <= 1'b1;
        m_data  <= lane_bus;
        m_last  <= (push_idx == n_eff - 4'd1);
      end else if (overrun_cnt != 16'hFFFF) begin
        overrun_cnt <= overrun_cnt + 16'd1;
      end
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ltc2333_readout.sv
// Self-checking bench for ltc2333_readout with a behavioural ADC bank model
// and a word-level reference of what each conversion must deliver.
module tb_ltc2333_readout;

  localparam int N        = 8;
  localparam int CLK_DIV  = 4;
  localparam int CNV_CYC  = 4;
  localparam int BUSY_TO  = 2000;
  localparam int DRAIN_TO = 64;
  localparam int DW       = 24 * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [31:0]   period = 32'd100;
  logic [3:0]    n_words = 4'd1;
  logic [23:0]   cfg_word = '0;
  logic          cnv, scki, sdi;
  logic [N-1:0]  busy, scko, sdo;
  logic          m_valid, m_last, busy_timeout;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic [15:0]   overrun_cnt;

  always #5 clk = ~clk;

  ltc2333_readout #(
    .N_ADC(N), .CLK_DIV(CLK_DIV), .CNV_CYC(CNV_CYC), .BUSY_TO(BUSY_TO), .DRAIN_TO(DRAIN_TO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .n_words(n_words),
    .cfg_word(cfg_word), .cnv(cnv), .scki(scki), .sdi(sdi), .busy(busy), .scko(scko),
    .sdo(sdo), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy_timeout(busy_timeout), .overrun_cnt(overrun_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC bank model: echo clock is SCKI delayed per lane, data advances on echo falls.
  logic [23:0]  lane_word [N][8];
  logic [N-1:0] stuck = '0;
  logic [7:0]   scki_hist = '0;
  logic         cnv_q = 1'b0;
  logic [N-1:0] scko_q = '0;
  int           bitpos [N];
  int           busy_cnt [N];

  always @(posedge clk) begin
    scki_hist <= {scki_hist[6:0], scki};
    cnv_q     <= cnv;
    scko_q    <= scko;
    for (int i = 0; i < N; i++) begin
      if (cnv && !cnv_q) begin
        bitpos[i]   <= 0;
        busy_cnt[i] <= 40 + 7 * i;
      end else begin
        if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
        if (scko_q[i] && !scko[i]) bitpos[i] <= bitpos[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      scko[i] = scki_hist[i % 3];
      busy[i] = stuck[i] || (busy_cnt[i] > 0);
      if (bitpos[i] < 192) sdo[i] = lane_word[i][bitpos[i] / 24][23 - (bitpos[i] % 24)];
      else                 sdo[i] = 1'b0;
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } xfer_t;

  xfer_t got[$];
  logic  sdi_bits[$];
  int    cnv_times[$];
  int    rises = 0;
  logic  scki_prev = 1'b0;
  logic  cnv_prev = 1'b0;

  always @(negedge clk) begin
    xfer_t t;
    if (!rst && m_valid && m_ready) begin
      t.data = m_data;
      t.last = m_last;
      got.push_back(t);
    end
    if (scki && !scki_prev) begin
      rises = rises + 1;
      sdi_bits.push_back(sdi);
    end
    if (cnv && !cnv_prev) cnv_times.push_back(cyc);
    scki_prev = scki;
    cnv_prev  = cnv;
  end

  typedef struct {
    int          n_in;
    logic [23:0] cfg;
    int          exp_words;
  } vec_t;

  vec_t tbl [4];

  function automatic int ref_words(int n);
    if (n < 1) return 1;
    if (n > 8) return 8;
    return n;
  endfunction

  task automatic checkOutput(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitCnv(int limit);
    int start = cnv_times.size();
    int k = 0;
    while (cnv_times.size() == start && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (cnv_times.size() == start) checkOutput("cnv timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic fillWords(int mode);
    for (int i = 0; i < N; i++)
      for (int w = 0; w < 8; w++)
        lane_word[i][w] = (mode == 0) ? ((w == 0) ? 24'hA5A5C0 + 24'(i) : 24'h0)
                                      : 24'($urandom);
  endtask

  task automatic applyStimulus(int nw, logic [23:0] cfg, int per, int mode);
    fillWords(mode);
    n_words  = 4'(nw);
    cfg_word = cfg;
    period   = 32'(per);
    got.delete();
    sdi_bits.delete();
    rises  = 0;
    enable = 1'b1;
    waitCnv(per + 200);
    enable = 1'b0;
    waitCycles(200 + 2 * CLK_DIV * 24 * ref_words(nw) + DRAIN_TO);
  endtask

  task automatic checkFrame(string tag, int exp_words, logic [23:0] cfg);
    logic [DW-1:0] exp_data;
    logic [23:0]   sdi_word;
    int            tail_ones;
    checkOutput({tag, " word count"}, DW'(got.size()), DW'(exp_words));
    for (int w = 0; w < got.size() && w < exp_words; w++) begin
      for (int i = 0; i < N; i++) exp_data[24*i +: 24] = lane_word[i][w];
      checkOutput({tag, $sformatf(" data[%0d]", w)}, got[w].data, exp_data);
      checkOutput({tag, $sformatf(" last[%0d]", w)}, DW'(got[w].last), DW'(w == exp_words - 1));
    end
    checkOutput({tag, " scki rises"}, DW'(rises), DW'(24 * exp_words));
    sdi_word  = '0;
    tail_ones = 0;
    for (int k = 0; k < sdi_bits.size(); k++) begin
      if (k < 24) sdi_word = {sdi_word[22:0], sdi_bits[k]};
      else if (sdi_bits[k]) tail_ones++;
    end
    checkOutput({tag, " sdi cfg"}, DW'(sdi_word), DW'(cfg));
    checkOutput({tag, " sdi tail"}, DW'(tail_ones), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] exp0;
    logic [23:0]   cfg;
    logic [15:0]   ov0;
    int            nw, guard, s;

    tbl[0] = '{8,  24'h123456, 8};
    tbl[1] = '{0,  24'hF0F00F, 1};
    tbl[2] = '{15, 24'h800001, 8};
    tbl[3] = '{3,  24'h5A5A5A, 3};
    fillWords(0);

    // Reset values
    waitCycles(5);
    checkOutput("rst cnv", DW'(cnv), 0);
    checkOutput("rst scki", DW'(scki), 0);
    checkOutput("rst sdi", DW'(sdi), 0);
    checkOutput("rst m_valid", DW'(m_valid), 0);
    checkOutput("rst m_data", m_data, 0);
    checkOutput("rst m_last", DW'(m_last), 0);
    checkOutput("rst busy_timeout", DW'(busy_timeout), 0);
    checkOutput("rst overrun_cnt", DW'(overrun_cnt), 0);
    @(negedge clk) rst = 1'b0;
    waitCycles(3);

    $display("[TB] single conversion");
    applyStimulus(1, 24'h9C3A51, 5000, 0);
    checkFrame("single", 1, 24'h9C3A51);

    $display("[TB] word-count table");
    for (int v = 0; v < 4; v++) begin
      applyStimulus(tbl[v].n_in, tbl[v].cfg, 100, 1);
      checkFrame($sformatf("tbl%0d", v), tbl[v].exp_words, tbl[v].cfg);
    end

    $display("[TB] random frames");
    for (int r = 0; r < 3; r++) begin
      nw  = $urandom_range(0, 15);
      cfg = 24'($urandom);
      applyStimulus(nw, cfg, 100, 1);
      checkFrame($sformatf("rand%0d", r), ref_words(nw), cfg);
    end

    $display("[TB] busy stuck");
    stuck    = 8'h08;
    n_words  = 4'd2;
    period   = 32'd100;
    got.delete();
    rises    = 0;
    enable   = 1'b1;
    waitCnv(300);
    enable = 1'b0;
    waitCycles(CNV_CYC + BUSY_TO - 20);
    checkOutput("timeout early", DW'(busy_timeout), 0);
    waitCycles(60);
    checkOutput("timeout set", DW'(busy_timeout), 1);
    waitCycles(100);
    checkOutput("timeout scki", DW'(rises), 0);
    checkOutput("timeout words", DW'(got.size()), 0);
    stuck = '0;
    applyStimulus(1, 24'hC0FFEE, 100, 1);
    checkOutput("timeout cleared", DW'(busy_timeout), 0);
    checkFrame("after timeout", 1, 24'hC0FFEE);

    $display("[TB] backpressure");
    m_ready = 1'b0;
    ov0     = overrun_cnt;
    applyStimulus(4, 24'h0A0B0C, 100, 1);
    for (int i = 0; i < N; i++) exp0[24*i +: 24] = lane_word[i][0];
    checkOutput("bp overrun", DW'(overrun_cnt - ov0), 3);
    checkOutput("bp valid held", DW'(m_valid), 1);
    checkOutput("bp data held", m_data, exp0);
    checkOutput("bp last held", DW'(m_last), 0);
    m_ready = 1'b1;
    waitCycles(3);
    checkOutput("bp transfers", DW'(got.size()), 1);
    if (got.size() > 0) checkOutput("bp first word", got[0].data, exp0);
    checkOutput("bp valid drop", DW'(m_valid), 0);

    $display("[TB] reset mid-shift");
    fillWords(1);
    n_words  = 4'd2;
    cfg_word = 24'h3C3C3C;
    period   = 32'd100;
    got.delete();
    rises    = 0;
    enable   = 1'b1;
    waitCnv(300);
    enable = 1'b0;
    guard  = 0;
    while (rises < 10 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    checkOutput("reach bit 10", DW'(rises >= 10), 1);
    rst = 1'b1;
    #1;
    checkOutput("mid rst outputs", DW'({cnv, scki, sdi, m_valid}), 0);
    waitCycles(3);
    @(negedge clk) rst = 1'b0;
    waitCycles(1500);
    checkOutput("mid rst no words", DW'(got.size()), 0);
    applyStimulus(2, 24'h3C3C3C, 100, 1);
    checkFrame("after rst", 2, 24'h3C3C3C);

    $display("[TB] period");
    fillWords(1);
    n_words = 4'd1;
    period  = 32'd5000;
    s       = cnv_times.size();
    enable  = 1'b1;
    guard   = 0;
    while (cnv_times.size() < s + 2 && guard < 12000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    enable = 1'b0;
    checkOutput("period edges", DW'(cnv_times.size() >= s + 2), 1);
    if (cnv_times.size() >= s + 2)
      checkOutput("period spacing", DW'(cnv_times[s+1] - cnv_times[s]), 5000);
    waitCycles(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
